// File: rtl/phoneme_sequencer_if.sv
// Avalon-MM read-only port between the phoneme sequencer and the speech flash.
interface phoneme_sequencer_if;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;

  modport master (output flash_mem_read, flash_mem_address,
                  input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid);
  modport slave  (input  flash_mem_read, flash_mem_address,
                  output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid);
endinterface

// File: rtl/phoneme_sequencer.sv
// Queues phoneme codes, resolves each to a flash word range via the narrator,
// streams those words out as 8-bit samples on sample_tick, or plays silence.
module phoneme_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int LOOKUP_LAT     = 2,
  parameter int SILENT_SAMPLES = 720
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phoneme_valid,
  input  logic [7:0]  phoneme_in,
  output logic        phoneme_ready,
  output logic [7:0]  phoneme_sel,
  input  logic [23:0] start_address,
  input  logic [23:0] end_address,
  input  logic        silent,
  phoneme_sequencer_if.master flash,
  input  logic        sample_tick,
  input  logic        pause,
  output logic [7:0]  audio_data,
  output logic        audio_valid,
  output logic        underrun,
  output logic        busy,
  output logic        done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (LOOKUP_LAT < 1) ? 1 : $clog2(LOOKUP_LAT + 1);
  localparam int SW = $clog2(SILENT_SAMPLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOOKUP, S_FETCH, S_WAIT, S_PLAY, S_SILENCE, S_NEXT
  } state_t;

  state_t state, state_n;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] sil_cnt;
  logic [23:0]   word_addr, end_r;
  logic [31:0]   word_r;
  logic [1:0]    byte_idx;
  logic          tick_ok;

  // Fullness is taken from the pre-pop count, so a push while full is lost
  // even if the FSM pops in the same cycle.
  assign full          = (count == (AW+1)'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign phoneme_ready = !reset && !full;
  assign push          = phoneme_valid && phoneme_ready;
  assign pop           = (state == S_POP);
  assign tick_ok       = sample_tick && !pause;

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= phoneme_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (!empty) state_n = S_POP;
      S_POP:     state_n = S_LOOKUP;
      S_LOOKUP:
        if (lat_cnt == '0) begin
          if (silent)                          state_n = S_SILENCE;
          else if (end_address < start_address) state_n = S_NEXT;
          else                                 state_n = S_FETCH;
        end
      S_FETCH:   if (!flash.flash_mem_waitrequest) state_n = S_WAIT;
      S_WAIT:    if (flash.flash_mem_readdatavalid) state_n = S_PLAY;
      S_PLAY:
        if (tick_ok && byte_idx == 2'd3)
          state_n = (word_addr == end_r) ? S_NEXT : S_FETCH;
      S_SILENCE: if (tick_ok && sil_cnt == SW'(1)) state_n = S_NEXT;
      S_NEXT:    state_n = empty ? S_IDLE : S_POP;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    flash.flash_mem_read    = (state == S_FETCH);
    flash.flash_mem_address = word_addr[22:0];
    busy                    = (state != S_IDLE) || !empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phoneme_sel <= '0;
      lat_cnt     <= '0;
      sil_cnt     <= '0;
      word_addr   <= '0;
      end_r       <= '0;
      word_r      <= '0;
      byte_idx    <= '0;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      underrun    <= 1'b0;
      done        <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      underrun    <= 1'b0;
      done        <= 1'b0;
      // A tick that lands while the next sample is still being prepared is lost.
      if (tick_ok && (state inside {S_POP, S_LOOKUP, S_FETCH, S_WAIT, S_NEXT}))
        underrun <= 1'b1;
      unique case (state)
        S_IDLE: audio_data <= '0;
        S_POP: begin
          phoneme_sel <= fifo_mem[rd_ptr];
          lat_cnt     <= LW'(LOOKUP_LAT);
        end
        S_LOOKUP:
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
          else begin
            word_addr <= start_address;
            end_r     <= end_address;
            sil_cnt   <= SW'(SILENT_SAMPLES);
          end
        S_WAIT:
          if (flash.flash_mem_readdatavalid) begin
            word_r   <= flash.flash_mem_readdata;
            byte_idx <= '0;
          end
        S_PLAY:
          if (tick_ok) begin
            audio_data  <= word_r[{byte_idx, 3'b000} +: 8];
            audio_valid <= 1'b1;
            byte_idx    <= byte_idx + 1'b1;
            if (byte_idx == 2'd3 && word_addr != end_r) word_addr <= word_addr + 1'b1;
          end
        S_SILENCE:
          if (tick_ok) begin
            audio_data  <= '0;
            audio_valid <= 1'b1;
            sil_cnt     <= sil_cnt - 1'b1;
          end
        S_NEXT:  if (empty) done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_phoneme_sequencer.sv
// Self-checking bench: narrator and flash models, sample scoreboard built from phoneme tables.
module tb_phoneme_sequencer;
  localparam int SIL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        phoneme_valid;
  logic [7:0]  phoneme_in;
  logic        phoneme_ready;
  logic [7:0]  phoneme_sel;
  logic [23:0] start_address, end_address;
  logic        silent;
  logic        sample_tick, pause;
  logic [7:0]  audio_data;
  logic        audio_valid, underrun, busy, done;

  always #5 clk = ~clk;

  phoneme_sequencer_if fl();

  phoneme_sequencer #(.FIFO_DEPTH(8), .LOOKUP_LAT(2), .SILENT_SAMPLES(SIL)) dut (
    .clk(clk), .reset(reset),
    .phoneme_valid(phoneme_valid), .phoneme_in(phoneme_in), .phoneme_ready(phoneme_ready),
    .phoneme_sel(phoneme_sel),
    .start_address(start_address), .end_address(end_address), .silent(silent),
    .flash(fl),
    .sample_tick(sample_tick), .pause(pause),
    .audio_data(audio_data), .audio_valid(audio_valid), .underrun(underrun),
    .busy(busy), .done(done)
  );

  int total = 0, bad = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Narrator: per-code tables, outputs follow phoneme_sel two cycles late.
  logic [23:0] n_start [256];
  logic [23:0] n_end   [256];
  logic        n_sil   [256];
  logic [7:0]  d1 = '0, d2 = '0;
  always @(posedge clk) begin
    d1 <= phoneme_sel;
    d2 <= d1;
  end
  assign start_address = n_start[d2];
  assign end_address   = n_end[d2];
  assign silent        = n_sil[d2];

  function automatic logic [31:0] mem_word(logic [22:0] a);
    if (a == 23'h100) return 32'h44332211;
    if (a == 23'h101) return 32'h88776655;
    return 32'(a) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  logic [7:0] got_q[$], exp_q[$];

  // Reference: what a phoneme should sound like, straight from the tables.
  task automatic add_expected(logic [7:0] code);
    if (n_sil[code]) begin
      for (int i = 0; i < SIL; i++) exp_q.push_back(8'h00);
    end else if (n_end[code] >= n_start[code]) begin
      for (logic [23:0] a = n_start[code]; a <= n_end[code]; a++) begin
        logic [31:0] w;
        w = mem_word(a[22:0]);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      end
    end
  endtask

  // Flash slave: random waitrequest, 0..3 cycle read latency, optional hold.
  logic        hold = 1'b0, force_wait = 1'b0;
  int          n_reads = 0, n_rdv = 0;
  logic [22:0] rd_addrs[$];
  initial begin
    logic        pend, prev_stall, prev_rst;
    logic [22:0] pend_addr, prev_addr;
    int          pend_cnt;
    pend = 1'b0; prev_stall = 1'b0; prev_rst = 1'b1; prev_addr = '0; pend_addr = '0; pend_cnt = 0;
    fl.flash_mem_waitrequest   = 1'b1;
    fl.flash_mem_readdatavalid = 1'b0;
    fl.flash_mem_readdata      = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_rst && !reset) begin
        check("rd_held_in_stall", fl.flash_mem_read, 1'b1);
        check("addr_held_in_stall", fl.flash_mem_address, prev_addr);
      end
      if (!reset && fl.flash_mem_read && !fl.flash_mem_waitrequest) begin
        pend      = 1'b1;
        pend_addr = fl.flash_mem_address;
        pend_cnt  = $urandom_range(0, 3);
        n_reads++;
        rd_addrs.push_back(fl.flash_mem_address);
      end
      prev_stall = fl.flash_mem_read && fl.flash_mem_waitrequest;
      prev_addr  = fl.flash_mem_address;
      prev_rst   = reset;
      @(posedge clk); #1;
      fl.flash_mem_readdatavalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0 && !hold) begin
          fl.flash_mem_readdatavalid = 1'b1;
          fl.flash_mem_readdata      = mem_word(pend_addr);
          pend = 1'b0;
          n_rdv++;
        end else if (pend_cnt > 0) pend_cnt--;
      end
      fl.flash_mem_waitrequest = force_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  end

  int n_under = 0, n_done = 0;
  initial forever begin
    @(negedge clk);
    if (audio_valid) got_q.push_back(audio_data);
    if (underrun)    n_under++;
    if (done)        n_done++;
  end

  int   tick_per = 0;
  logic man_tick = 1'b0;
  initial begin
    int tcnt;
    tcnt = 0;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      sample_tick = man_tick;
      man_tick    = 1'b0;
      if (tick_per > 0) begin
        tcnt++;
        if (tcnt >= tick_per) begin sample_tick = 1'b1; tcnt = 0; end
      end
    end
  end

  task automatic tick_now();
    @(negedge clk); man_tick = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_cycle(logic [7:0] code, output logic acc);
    @(posedge clk); #1;
    phoneme_valid = 1'b1;
    phoneme_in    = code;
    @(negedge clk);
    acc = phoneme_ready;
  endtask

  task automatic push_end();
    @(posedge clk); #1;
    phoneme_valid = 1'b0;
  endtask

  task automatic push_one(logic [7:0] code);
    logic acc;
    push_cycle(code, acc);
    push_end();
    check("push_accepted", acc, 1'b1);
    if (acc) add_expected(code);
  endtask

  task automatic wait_done(int tgt, int bound);
    for (int i = 0; i < bound && n_done < tgt; i++) @(negedge clk);
    check("done_within_bound", n_done >= tgt, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_reads(int tgt, int bound);
    for (int i = 0; i < bound && n_reads < tgt; i++) @(negedge clk);
    check("read_within_bound", n_reads >= tgt, 1'b1);
  endtask

  task automatic compare_samples(string tag);
    check(tag, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   d0, r0, u0;
    logic acc;
    logic [7:0] a0, codes[$];
    logic [31:0] w;

    for (int c = 0; c < 256; c++) begin
      n_sil[c]   = ($urandom_range(0, 5) == 0);
      n_start[c] = 24'($urandom_range(16, 24'h3FFFFF));
      n_end[c]   = n_start[c] + 24'($urandom_range(0, 3)) - 24'd1;
    end
    n_sil[8'h05] = 0; n_start[8'h05] = 24'h100;  n_end[8'h05] = 24'h101;
    n_sil[8'h06] = 0; n_start[8'h06] = 24'h300;  n_end[8'h06] = 24'h300;
    n_sil[8'h07] = 0; n_start[8'h07] = 24'h400;  n_end[8'h07] = 24'h400;
    n_sil[8'h08] = 0; n_start[8'h08] = 24'h500;  n_end[8'h08] = 24'h501;
    n_sil[8'h10] = 1; n_start[8'h10] = 24'h600;  n_end[8'h10] = 24'h6FF;
    n_sil[8'h20] = 0; n_start[8'h20] = 24'h2000; n_end[8'h20] = 24'h2007;
    n_sil[8'h30] = 0; n_start[8'h30] = 24'h700;  n_end[8'h30] = 24'h6FF;

    reset = 1'b1; phoneme_valid = 1'b0; phoneme_in = '0; pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", phoneme_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_read", fl.flash_mem_read, 1'b0);
    check("rst_audio", {audio_data, audio_valid, underrun, done}, '0);
    check("rst_sel", phoneme_sel, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", phoneme_ready, 1'b1);

    // Two-word phoneme with slow ticks
    tick_per = 100; d0 = n_done; r0 = n_reads; rd_addrs.delete();
    push_one(8'h05);
    wait_done(d0 + 1, 3000);
    tick_per = 0;
    check("t1_reads", n_reads - r0, 2);
    check("t1_addr0", rd_addrs.size() > 0 ? rd_addrs[0] : 23'h7FFFFF, 23'h100);
    check("t1_addr1", rd_addrs.size() > 1 ? rd_addrs[1] : 23'h7FFFFF, 23'h101);
    check("t1_sel", phoneme_sel, 8'h05);
    compare_samples("t1_samples");
    repeat (20) @(negedge clk);
    check("t1_done_once", n_done - d0, 1);
    check("t1_busy_low", busy, 1'b0);

    // Stalled FETCH: request held while waitrequest stays high
    force_wait = 1'b1; r0 = n_reads; d0 = n_done;
    push_one(8'h06);
    for (int i = 0; i < 50 && !fl.flash_mem_read; i++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t2_read_held", fl.flash_mem_read, 1'b1);
      check("t2_addr_held", fl.flash_mem_address, 23'h300);
    end
    check("t2_no_accept", n_reads - r0, 0);
    force_wait = 1'b0; tick_per = 10;
    wait_done(d0 + 1, 2000);
    tick_per = 0;
    check("t2_one_read", n_reads - r0, 1);
    compare_samples("t2_samples");

    // Silent phoneme: zero samples, no flash traffic
    r0 = n_reads; d0 = n_done; tick_per = 10;
    push_one(8'h10);
    wait_done(d0 + 1, 1000);
    tick_per = 0;
    check("t3_no_reads", n_reads - r0, 0);
    compare_samples("t3_samples");

    // Underrun in WAIT_DATA, then pause inside PLAY
    hold = 1'b1; r0 = n_reads; d0 = n_done;
    push_one(8'h07);
    wait_reads(r0 + 1, 200);
    repeat (2) @(negedge clk);
    a0 = audio_data; u0 = n_under;
    tick_now();
    check("t4_underrun", n_under - u0, 1);
    check("t4_no_sample", got_q.size(), 0);
    check("t4_audio_hold", audio_data, a0);
    r0 = n_rdv; hold = 1'b0;
    for (int i = 0; i < 50 && n_rdv == r0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    pause = 1'b1; u0 = n_under;
    repeat (3) tick_now();
    check("t4_pause_no_valid", got_q.size(), 0);
    check("t4_pause_no_underrun", n_under - u0, 0);
    check("t4_pause_audio_hold", audio_data, a0);
    pause = 1'b0;
    repeat (4) tick_now();
    wait_done(d0 + 1, 100);
    w = mem_word(23'h400);
    check("t4_byte0_first", got_q.size() > 0 ? got_q[0] : 8'hXX, w[7:0]);
    compare_samples("t4_samples");

    // Reset while a read is outstanding; late readdatavalid must be ignored
    hold = 1'b1; r0 = n_reads; d0 = n_done;
    push_one(8'h08);
    wait_reads(r0 + 1, 200);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_ready", phoneme_ready, 1'b0);
    check("t5_rst_read", fl.flash_mem_read, 1'b0);
    check("t5_rst_sel", phoneme_sel, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    hold = 1'b0; tick_per = 3;
    repeat (30) @(negedge clk);
    tick_per = 0;
    check("t5_no_samples", got_q.size(), 0);
    check("t5_idle_busy", busy, 1'b0);
    check("t5_idle_audio", audio_data, 8'h00);
    check("t5_no_done", n_done - d0, 0);
    exp_q.delete();

    // Long phoneme holds the FIFO; 9 back-to-back pushes, 9th dropped
    r0 = n_reads; d0 = n_done;
    push_one(8'h20);
    wait_reads(r0 + 1, 200);
    codes = '{8'h30, 8'h10, 8'h05, 8'h30, 8'h06, 8'h10, 8'h07, 8'h05, 8'h11};
    for (int i = 0; i < 9; i++) begin
      push_cycle(codes[i], acc);
      check("t6_ready", acc, (i < 8) ? 1'b1 : 1'b0);
      if (acc) add_expected(codes[i]);
    end
    push_end();
    tick_per = 5;
    wait_done(d0 + 1, 8000);
    tick_per = 0;
    compare_samples("t6_samples");
    check("t6_done_once", n_done - d0, 1);

    // Random codes with random tables
    d0 = n_done; tick_per = 8;
    for (int i = 0; i < 14; i++) begin
      logic [7:0] c;
      c = 8'($urandom_range(8'h40, 8'hFF));
      acc = 1'b0;
      for (int k = 0; k < 2000 && !acc; k++) push_cycle(c, acc);
      if (acc) add_expected(c);
    end
    push_end();
    wait_done(d0 + 1, 20000);
    tick_per = 0;
    compare_samples("t7_samples");
    repeat (10) @(negedge clk);
    check("t7_done_once", n_done - d0, 1);
    check("t7_busy_low", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phoneme_sequencer.md
Name: phoneme_sequencer

Overview:
- Sequences speech playback between the PicoBlaze, the narrator lookup and the flash Avalon port.
- Queues phoneme codes from the PicoBlaze and presents each one to narrator_ctrl to get its word-address range.
- Fetches that range from flash one 32-bit word at a time and emits one 8-bit sample per sample_tick.
- Silent phonemes produce zero samples for a fixed duration, with no flash access.

Parameters:
FIFO_DEPTH, 8, phoneme queue entries (power of 2, >=2)
LOOKUP_LAT, 2, clk cycles from phoneme_sel change to valid start_address/end_address/silent
SILENT_SAMPLES, 720, zero samples emitted for a silent phoneme (100 ms at 7.2 kHz)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
phoneme_valid  in  1  push strobe from PicoBlaze side
phoneme_in  in  8  phoneme code to queue
phoneme_ready  out  1  queue not full
phoneme_sel  out  8  code presented to narrator_ctrl
start_address  in  24  first word address of phoneme (from narrator)
end_address  in  24  last word address, inclusive
silent  in  1  phoneme is silence
flash_mem_read  out  1  Avalon read request
flash_mem_address  out  23  Avalon word address
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdata  in  32  Avalon read data
flash_mem_readdatavalid  in  1  Avalon data strobe
sample_tick  in  1  single-cycle strobe, synchronised 7.2 kHz edge
pause  in  1  hold playback
audio_data  out  8  current sample
audio_valid  out  1  one-cycle pulse when audio_data updates
underrun  out  1  one-cycle pulse: tick arrived with no sample ready
busy  out  1  state != IDLE or queue non-empty
done  out  1  one-cycle pulse when last queued phoneme finishes

Behaviour:
- Reset values: all outputs 0 while reset is high, including phoneme_ready. Queue is emptied, FSM goes to IDLE. Reset mid-read drops flash_mem_read the next cycle; any later readdatavalid is ignored.
- Queue: push on phoneme_valid && phoneme_ready. phoneme_ready = !full, evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs. Push and pop in the same cycle when not full: count unchanged.
- States and transitions:
  - IDLE: audio_data = 0. Goes to POP when the queue is non-empty.
  - POP: dequeue; phoneme_sel <= code; counter <= LOOKUP_LAT; go to LOOKUP.
  - LOOKUP: decrement counter. At 0, latch start, end and silent, then:
    - silent -> SILENCE, sample counter = SILENT_SAMPLES;
    - end < start -> NEXT (phoneme skipped, no samples);
    - otherwise word_addr <= start, go to FETCH.
  - FETCH: flash_mem_read=1, flash_mem_address=word_addr[22:0]. Both are held stable until a cycle with waitrequest=0, then go to WAIT_DATA. Burst length is always 1.
  - WAIT_DATA: on readdatavalid, latch the word, byte_idx <= 0, go to PLAY.
  - PLAY: on sample_tick && !pause:
    - audio_data <= word byte[byte_idx], byte 0 = bits 7:0 first; audio_valid pulses the next cycle.
    - byte_idx increments.
    - After byte 3: if word_addr == end go to NEXT, else word_addr+1 and go to FETCH.
  - SILENCE: on sample_tick && !pause: audio_data <= 0, audio_valid pulse, decrement. At 0 go to NEXT.
  - NEXT: queue non-empty -> POP; else done pulse and go to IDLE.
- Output latency: audio_data and audio_valid register one cycle after the accepted tick.
- Ticks outside PLAY/SILENCE:
  - In FETCH, WAIT_DATA, LOOKUP, POP or NEXT with busy=1 and pause=0: underrun pulses and audio_data holds.
  - In IDLE: ignored.
- pause: ticks are ignored and audio_data holds. Flash transactions in flight still complete. The FSM stalls only in PLAY and SILENCE.
- Arithmetic: word_addr is 24-bit, incremented without wrap check. end == start yields exactly 4 samples. A range of N words yields 4N samples.
- busy is combinational from state and queue count.

Test Plan:
- Push 0x05 with start=0x100, end=0x101, flash returns 0x44332211 then 0x88776655, ticks every 100 cycles -> reads at 0x100 then 0x101; audio_data 11,22,33,44,55,66,77,88 with 8 audio_valid pulses; done pulses once; busy falls.
- waitrequest held high 20 cycles in FETCH -> flash_mem_read and flash_mem_address stay stable all 20 cycles; exactly one read accepted.
- Silent phoneme, SILENT_SAMPLES=4 -> 4 zero samples, no flash_mem_read.
- Push 9 codes back-to-back while playing a long phoneme with FIFO_DEPTH=8 -> phoneme_ready drops after 8 queued; 9th dropped; exactly 8 phonemes played.
- Tick issued in WAIT_DATA -> underrun pulses, audio_data unchanged. pause=1 across 3 ticks in PLAY -> no audio_valid, byte_idx unchanged.
- Reset asserted mid-WAIT_DATA, then readdatavalid arrives -> all outputs 0, FSM in IDLE, data ignored; end < start phoneme -> zero samples, proceeds to next.
